// File: rtl/sram_tap_pkg.sv
// rtl/sram_tap_pkg.sv - state encoding, width helpers and tap-address math for sram_tap_buffer
package sram_tap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_CLR   = 2'd2
  } tapState_t;

  function automatic int chWidth(input int numCh);
    return (numCh > 1) ? $clog2(numCh) : 1;
  endfunction

  function automatic int addrWidth(input int depth, input int numCh);
    return chWidth(numCh) + $clog2(depth);
  endfunction

  // Ring slot of tap k behind the write pointer; depth is a power of two so the mask wraps.
  function automatic int tapPtr(input int wptr, input int k, input int depth);
    return (wptr - 1 - k) & (depth - 1);
  endfunction

endpackage

// File: rtl/sram_tap_mem.sv
// rtl/sram_tap_mem.sv - single-port sample array with registered read data and no array reset
module sram_tap_mem #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_W     = 5
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/sram_tap_buffer.sv
// rtl/sram_tap_buffer.sv - multi-channel circular tap buffer on one single-port array
// Optional power-up clear sweep of the array: `SRAM_TAP_CLR_EN.
module sram_tap_buffer
  import sram_tap_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int NUM_CH     = 2,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CH_W      = chWidth(NUM_CH),
  localparam int ADDR_W    = addrWidth(DEPTH, NUM_CH)
) (
  input  logic                  iClk_12M,
  input  logic                  iRst,
  input  logic                  iWrEn,
  input  logic [CH_W-1:0]       iWrCh,
  input  logic [DATA_WIDTH-1:0] iWrDt,
  input  logic                  iRdStart,
  input  logic [CH_W-1:0]       iRdCh,
  output logic [DATA_WIDTH-1:0] oRdDt,
  output logic                  oRdVld,
  output logic [PTR_W-1:0]      oRdTapIdx,
  output logic                  oRdLast,
  output logic                  oBusy,
  output logic                  oWrDrop
);

  localparam logic [CH_W:0]    NUM_CH_L = (CH_W+1)'(NUM_CH);
  localparam logic [PTR_W-1:0] LAST_TAP = PTR_W'(DEPTH - 1);

`ifdef SRAM_TAP_CLR_EN
  localparam tapState_t         RESET_STATE = ST_CLR;
  localparam logic [ADDR_W-1:0] CLR_LAST    = ADDR_W'(NUM_CH * DEPTH - 1);
  logic [ADDR_W-1:0] clrAddr;
`else
  localparam tapState_t RESET_STATE = ST_IDLE;
`endif

  tapState_t             state;
  logic [PTR_W-1:0]      wptr [NUM_CH];
  logic                  pending;
  logic [CH_W-1:0]       pendCh;
  logic [CH_W-1:0]       burstCh;
  logic [PTR_W-1:0]      burstPtr;
  logic [PTR_W-1:0]      tapCnt;
  logic                  rdVld;
  logic [PTR_W-1:0]      rdTapIdx;
  logic                  rdLast;
  logic [DATA_WIDTH-1:0] rdHold;
  logic                  wrDrop;

  logic                  memWe;
  logic [ADDR_W-1:0]     memAddr;
  logic [DATA_WIDTH-1:0] memWdata;
  logic [DATA_WIDTH-1:0] memRdata;

  logic                  isIdle;
  logic                  wrAccept;
  logic                  startReq;
  logic [CH_W-1:0]       startCh;
  logic [PTR_W-1:0]      tapPtrNow;

  assign isIdle    = (state == ST_IDLE);
  assign wrAccept  = isIdle && iWrEn && ({1'b0, iWrCh} < NUM_CH_L);
  assign startReq  = isIdle && (pending || (iRdStart && ({1'b0, iRdCh} < NUM_CH_L)));
  assign startCh   = pending ? pendCh : iRdCh;
  assign tapPtrNow = PTR_W'(tapPtr(int'(burstPtr), int'(tapCnt), DEPTH));

  always_comb begin
    memWe    = 1'b0;
    memAddr  = {burstCh, tapPtrNow};
    memWdata = iWrDt;
    case (state)
      ST_IDLE: begin
        if (wrAccept) begin
          memWe   = 1'b1;
          memAddr = {iWrCh, wptr[iWrCh]};
        end
      end
`ifdef SRAM_TAP_CLR_EN
      ST_CLR: begin
        memWe    = 1'b1;
        memAddr  = clrAddr;
        memWdata = '0;
      end
`endif
      default: ;
    endcase
  end

  sram_tap_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_W    (ADDR_W)
  ) uMem (
    .clk  (iClk_12M),
    .we   (memWe),
    .addr (memAddr),
    .wdata(memWdata),
    .rdata(memRdata)
  );

  always_ff @(posedge iClk_12M or posedge iRst) begin
    if (iRst) begin
      state    <= RESET_STATE;
      for (int i = 0; i < NUM_CH; i++) wptr[i] <= '0;
      pending  <= 1'b0;
      pendCh   <= '0;
      burstCh  <= '0;
      burstPtr <= '0;
      tapCnt   <= '0;
      rdVld    <= 1'b0;
      rdTapIdx <= '0;
      rdLast   <= 1'b0;
      rdHold   <= '0;
      wrDrop   <= 1'b0;
`ifdef SRAM_TAP_CLR_EN
      clrAddr  <= '0;
`endif
    end else begin
      // Strobes are registered in the address-issue cycle so they line up with memRdata.
      rdVld    <= (state == ST_BURST);
      rdTapIdx <= (state == ST_BURST) ? tapCnt : '0;
      rdLast   <= (state == ST_BURST) && (tapCnt == LAST_TAP);
      if (rdVld) rdHold <= memRdata;
      wrDrop   <= iWrEn && !wrAccept;
      if (wrAccept) wptr[iWrCh] <= wptr[iWrCh] + 1'b1;

      case (state)
        ST_IDLE: begin
          if (startReq) begin
            // A write in the same cycle owns the port; defer the start so tap 0 is the new sample.
            if (wrAccept) begin
              pending <= 1'b1;
              pendCh  <= startCh;
            end else begin
              pending  <= 1'b0;
              burstCh  <= startCh;
              burstPtr <= wptr[startCh];
              tapCnt   <= '0;
              state    <= ST_BURST;
            end
          end
        end
        ST_BURST: begin
          tapCnt <= tapCnt + 1'b1;
          if (tapCnt == LAST_TAP) state <= ST_IDLE;
        end
`ifdef SRAM_TAP_CLR_EN
        ST_CLR: begin
          clrAddr <= clrAddr + 1'b1;
          if (clrAddr == CLR_LAST) state <= ST_IDLE;
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign oRdDt     = rdVld ? memRdata : rdHold;
  assign oRdVld    = rdVld;
  assign oRdTapIdx = rdTapIdx;
  assign oRdLast   = rdLast;
  assign oBusy     = !isIdle;
  assign oWrDrop   = wrDrop;

endmodule

// File: tb/tb_sram_tap_buffer.sv
// tb/tb_sram_tap_buffer.sv - self-checking bench for sram_tap_buffer (also builds with `SRAM_TAP_CLR_EN)
module tb_sram_tap_buffer;

  localparam int DW     = 16;
  localparam int DEPTH  = 16;
  localparam int NUM_CH = 2;
  localparam int PTR_W  = 4;
  localparam int CH_W   = 1;
`ifdef SRAM_TAP_CLR_EN
  localparam int CLR_ON = 1;
`else
  localparam int CLR_ON = 0;
`endif

  logic            iClk_12M = 1'b0;
  logic            iRst     = 1'b0;
  logic            iWrEn    = 1'b0;
  logic [CH_W-1:0] iWrCh    = '0;
  logic [DW-1:0]   iWrDt    = '0;
  logic            iRdStart = 1'b0;
  logic [CH_W-1:0] iRdCh    = '0;
  logic [DW-1:0]   oRdDt;
  logic            oRdVld;
  logic [PTR_W-1:0] oRdTapIdx;
  logic            oRdLast;
  logic            oBusy;
  logic            oWrDrop;

  int nRun  = 0;
  int nFail = 0;

  // Reference: array indexed by the documented {ch, ptr} map plus per-channel write pointers.
  logic [DW-1:0] mMem   [NUM_CH][DEPTH];
  bit            mKnown [NUM_CH][DEPTH];
  int            mWptr  [NUM_CH];

  typedef struct {
    bit            wrEn;
    bit            rdStart;
    logic [DW-1:0] wrDt;
    bit            expVld;
    int            expIdx;
    bit            expLast;
    int            expDt;
    bit            expBusy;
  } vec_t;

  vec_t vecs [35];

  sram_tap_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_CH(NUM_CH)) dut (
    .iClk_12M (iClk_12M),
    .iRst     (iRst),
    .iWrEn    (iWrEn),
    .iWrCh    (iWrCh),
    .iWrDt    (iWrDt),
    .iRdStart (iRdStart),
    .iRdCh    (iRdCh),
    .oRdDt    (oRdDt),
    .oRdVld   (oRdVld),
    .oRdTapIdx(oRdTapIdx),
    .oRdLast  (oRdLast),
    .oBusy    (oBusy),
    .oWrDrop  (oWrDrop)
  );

  always #40 iClk_12M = ~iClk_12M;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    nRun++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge iClk_12M);
    #1;
  endtask

  task automatic mWrite(input int ch, input logic [DW-1:0] d);
    mMem[ch][mWptr[ch]]   = d;
    mKnown[ch][mWptr[ch]] = 1'b1;
    mWptr[ch] = (mWptr[ch] + 1) % DEPTH;
  endtask

  task automatic mReset();
    for (int c = 0; c < NUM_CH; c++) begin
      mWptr[c] = 0;
      if (CLR_ON != 0)
        for (int p = 0; p < DEPTH; p++) begin
          mMem[c][p]   = '0;
          mKnown[c][p] = 1'b1;
        end
    end
  endtask

  task automatic afterReset();
    if (CLR_ON != 0) begin
      for (int c = 0; c < NUM_CH * DEPTH; c++) begin
        check("clr busy", int'(oBusy), 1);
        if (c == 0) begin
          iWrEn = 1'b1; iWrCh = '0; iWrDt = 16'h1234;
          iRdStart = 1'b1; iRdCh = '0;
        end
        step();
        iWrEn = 1'b0; iRdStart = 1'b0;
        if (c == 0) check("clr drop", int'(oWrDrop), 1);
      end
    end
    check("idle busy", int'(oBusy), 0);
    check("idle vld", int'(oRdVld), 0);
  endtask

  task automatic wrCycle(input int ch, input logic [DW-1:0] d);
    iWrEn = 1'b1; iWrCh = CH_W'(ch); iWrDt = d;
    step();
    iWrEn = 1'b0;
    mWrite(ch, d);
    check("idle write drop", int'(oWrDrop), 0);
  endtask

  task automatic runBurst(input int ch, input bit withWrite, input logic [DW-1:0] wd, input bit noise);
    logic [DW-1:0] expTap [DEPTH];
    bit            knownTap [DEPTH];
    int            lat;
    int            p;
    int            k;
    int            wch;
    bit            busyNow;
    bit            dropExp;
    logic [DW-1:0] wdt;
    iRdStart = 1'b1; iRdCh = CH_W'(ch);
    if (withWrite) begin
      iWrEn = 1'b1; iWrCh = CH_W'(ch); iWrDt = wd;
      mWrite(ch, wd);
    end
    for (int t = 0; t < DEPTH; t++) begin
      p = (mWptr[ch] - 1 - t + 2 * DEPTH) % DEPTH;
      expTap[t]   = mMem[ch][p];
      knownTap[t] = mKnown[ch][p];
    end
    lat = withWrite ? 3 : 2;
    step();
    iRdStart = 1'b0; iWrEn = 1'b0;
    dropExp = 1'b0;
    for (int c = 1; c <= lat + DEPTH; c++) begin
      k = c - lat;
      busyNow = (c >= lat - 1) && (c <= lat + DEPTH - 2);
      check("burst wrdrop", int'(oWrDrop), int'(dropExp));
      check("burst busy", int'(oBusy), int'(busyNow));
      if (k >= 0 && k < DEPTH) begin
        check("burst vld", int'(oRdVld), 1);
        check("burst idx", int'(oRdTapIdx), k);
        check("burst last", int'(oRdLast), int'(k == DEPTH - 1));
        if (knownTap[k]) check("burst data", int'(oRdDt), int'(expTap[k]));
      end else begin
        check("gap vld", int'(oRdVld), 0);
        check("gap idx", int'(oRdTapIdx), 0);
        check("gap last", int'(oRdLast), 0);
        if (k == DEPTH && knownTap[DEPTH-1]) check("hold data", int'(oRdDt), int'(expTap[DEPTH-1]));
      end
      dropExp = 1'b0;
      if (noise && (busyNow || c == lat + DEPTH - 1)) begin
        if ($urandom_range(1, 0) == 1) begin
          wch = int'($urandom_range(NUM_CH - 1, 0));
          wdt = DW'($urandom);
          iWrEn = 1'b1; iWrCh = CH_W'(wch); iWrDt = wdt;
          if (busyNow) dropExp = 1'b1;
          else mWrite(wch, wdt);
        end
        if (busyNow && $urandom_range(1, 0) == 1) begin
          iRdStart = 1'b1; iRdCh = CH_W'($urandom_range(NUM_CH - 1, 0));
        end
      end
      step();
      iWrEn = 1'b0; iRdStart = 1'b0;
    end
    if (noise)
      for (int c = 0; c < 2; c++) begin
        check("no 2nd burst vld", int'(oRdVld), 0);
        check("no 2nd burst busy", int'(oBusy), 0);
        step();
      end
  endtask

  initial begin
    for (int c = 0; c < NUM_CH; c++)
      for (int p = 0; p < DEPTH; p++) begin
        mMem[c][p]   = '0;
        mKnown[c][p] = 1'b0;
      end
    mReset();

    // Reset state
    #1 iRst = 1'b1;
    repeat (3) step();
    check("rst vld", int'(oRdVld), 0);
    check("rst dt", int'(oRdDt), 0);
    check("rst idx", int'(oRdTapIdx), 0);
    check("rst last", int'(oRdLast), 0);
    check("rst drop", int'(oWrDrop), 0);
    check("rst busy", int'(oBusy), CLR_ON);
    iRst = 1'b0;
    afterReset();

    // Test 1: write 1..16 to ch0, burst ch0, table of per-cycle vectors
    for (int i = 0; i < 35; i++) begin
      vecs[i] = '{wrEn: 1'b0, rdStart: 1'b0, wrDt: '0, expVld: 1'b0, expIdx: 0,
                  expLast: 1'b0, expDt: 0, expBusy: 1'b0};
      if (i < 16) begin
        vecs[i].wrEn = 1'b1;
        vecs[i].wrDt = DW'(i + 1);
      end else if (i == 16) begin
        vecs[i].rdStart = 1'b1;
      end else if (i == 17) begin
        vecs[i].expBusy = 1'b1;
      end else if (i < 34) begin
        vecs[i].expVld  = 1'b1;
        vecs[i].expIdx  = i - 18;
        vecs[i].expLast = (i == 33);
        vecs[i].expDt   = 16 - (i - 18);
        vecs[i].expBusy = (i != 33);
      end else begin
        vecs[i].expDt = 1;
      end
    end
    for (int i = 0; i < 35; i++) begin
      iWrEn = vecs[i].wrEn; iWrCh = '0; iWrDt = vecs[i].wrDt;
      iRdStart = vecs[i].rdStart; iRdCh = '0;
      check("t1 vld", int'(oRdVld), int'(vecs[i].expVld));
      check("t1 idx", int'(oRdTapIdx), vecs[i].expIdx);
      check("t1 last", int'(oRdLast), int'(vecs[i].expLast));
      check("t1 dt", int'(oRdDt), vecs[i].expDt);
      check("t1 busy", int'(oBusy), int'(vecs[i].expBusy));
      if (vecs[i].wrEn) mWrite(0, vecs[i].wrDt);
      step();
    end
    iWrEn = 1'b0; iRdStart = 1'b0;

    // Test 2: wrap on ch0, then single write to ch1 leaves ch0 alone
    for (int d = 1; d <= 20; d++) wrCycle(0, DW'(d));
    runBurst(0, 1'b0, '0, 1'b0);
    wrCycle(1, 16'd7);
    runBurst(1, 1'b0, '0, 1'b0);
    runBurst(0, 1'b0, '0, 1'b0);

    // Test 3: write and start in the same idle cycle
    runBurst(0, 1'b1, 16'd99, 1'b0);

    // Test 4: writes/starts while busy, write in the last-data cycle
    repeat (3) runBurst(0, 1'b0, '0, 1'b1);

    // Test 5: reset during tap 5
    iRdStart = 1'b1; iRdCh = '0;
    step();
    iRdStart = 1'b0;
    repeat (6) step();
    check("t5 pre vld", int'(oRdVld), 1);
    check("t5 pre idx", int'(oRdTapIdx), 5);
    check("t5 pre dt", int'(oRdDt), int'(mMem[0][(mWptr[0] - 6 + DEPTH) % DEPTH]));
    iRst = 1'b1;
    #1;
    check("t5 async vld", int'(oRdVld), 0);
    check("t5 async dt", int'(oRdDt), 0);
    check("t5 async idx", int'(oRdTapIdx), 0);
    check("t5 async last", int'(oRdLast), 0);
    check("t5 async busy", int'(oBusy), CLR_ON);
    step();
    step();
    iRst = 1'b0;
    mReset();
    afterReset();
    wrCycle(0, 16'h5A5A);
    runBurst(0, 1'b0, '0, 1'b0);
    runBurst(1, 1'b0, '0, 1'b0);

    // Randomized traffic against the reference
    for (int it = 0; it < 25; it++) begin
      int nw;
      nw = int'($urandom_range(5, 0));
      for (int w = 0; w < nw; w++)
        wrCycle(int'($urandom_range(NUM_CH - 1, 0)), DW'($urandom));
      runBurst(int'($urandom_range(NUM_CH - 1, 0)), bit'($urandom_range(1, 0)), DW'($urandom), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", nRun, nFail);
    $finish;
  end

endmodule
